// File: rtl/mls_pkg.sv
// Shared state type, feedback tap table and marker constant for the MLS burst generator.
// Tap bit j selects LFSR state bit j (bit 0 = oldest chip) into the feedback XOR.
package mls_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP
  } mls_state_e;

  localparam int ORDER_MIN = 2;
  localparam int TAP_W     = 16;

  // Primitive polynomials x^n + ... + 1 for orders 2..16.
  function automatic logic [TAP_W-1:0] tap_mask(input logic [4:0] order);
    case (order)
      5'd2:    return 16'h0003;
      5'd3:    return 16'h0003;
      5'd4:    return 16'h0003;
      5'd5:    return 16'h0005;
      5'd6:    return 16'h0003;
      5'd7:    return 16'h0003;
      5'd8:    return 16'h001D;
      5'd9:    return 16'h0011;
      5'd10:   return 16'h0009;
      5'd11:   return 16'h0005;
      5'd12:   return 16'h0941;
      5'd13:   return 16'h1601;
      5'd14:   return 16'h2A01;
      5'd15:   return 16'h0003;
      default: return 16'h100B;
    endcase
  endfunction

  // Largest positive sample for a given DAC width.
  function automatic logic [15:0] marker_value(input int dac_w);
    return 16'((1 << (dac_w - 1)) - 1);
  endfunction

endpackage

// File: rtl/mls_lfsr.sv
// Order-selectable Fibonacci LFSR: shifts toward bit 0, chip is bit 0, feedback enters bit order-1.
// Seed loads all ones within the active order; period_end flags the step that returns to the seed.
module mls_lfsr
  import mls_pkg::*;
#(
  parameter int MAX_ORDER = 16
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [4:0] order,
  input  logic       seed,
  input  logic       step,
  output logic       chip,
  output logic       period_end
);

  logic [MAX_ORDER-1:0] lfsr_q;
  logic [MAX_ORDER-1:0] lfsr_nxt;
  logic [MAX_ORDER-1:0] used_mask;
  logic [MAX_ORDER-1:0] taps;
  logic [TAP_W-1:0]     tap_full;
  logic                 fb;

  always_comb begin
    tap_full  = tap_mask(order);
    taps      = tap_full[MAX_ORDER-1:0];
    fb        = ^(lfsr_q & taps);
    used_mask = '0;
    lfsr_nxt  = '0;
    for (int i = 0; i < MAX_ORDER - 1; i++) begin
      if (i < int'(order) - 1) lfsr_nxt[i] = lfsr_q[i+1];
    end
    for (int i = 0; i < MAX_ORDER; i++) begin
      if (i < int'(order)) used_mask[i] = 1'b1;
      if (i == int'(order) - 1) lfsr_nxt[i] = fb;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr_q <= '1;
    end else if (seed) begin
      lfsr_q <= used_mask;
    end else if (step) begin
      lfsr_q <= lfsr_nxt;
    end
  end

  assign chip       = lfsr_q[0];
  assign period_end = (lfsr_nxt == used_mask);

endmodule

// File: rtl/axis_mls_burst_gen.sv
// AXI-Stream MLS burst source for DAC ch A; first beat one cycle after cfg_start; MLS_MARKER_EN adds a ch B marker.
// Beats hold while m_axis_tready is low; LFSR and all counters advance only on accepted beats.
module axis_mls_burst_gen
  import mls_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int DAC_DATA_WIDTH   = 14,
  parameter int LFSR_MAX_ORDER   = 16,
  parameter int DIV_WIDTH        = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_start,
  input  logic                        cfg_stop,
  input  logic [4:0]                  cfg_order,
  input  logic [DIV_WIDTH-1:0]        cfg_div,
  input  logic [7:0]                  cfg_rep,
  input  logic [15:0]                 cfg_gap,
  input  logic [DAC_DATA_WIDTH-2:0]   cfg_amp,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        busy_o,
  output logic                        seq_end_o,
  output logic                        done_o
);

  mls_state_e                state_q, state_nxt;
  logic [4:0]                order_q, order_clamp, lfsr_order;
  logic [DIV_WIDTH-1:0]      div_q, div_cnt;
  logic [7:0]                rep_q, rep_cnt;
  logic [15:0]               gap_q, gap_cnt;
  logic [DAC_DATA_WIDTH-2:0] amp_q;
  logic                      stop_pend;
  logic                      start_ok, beat_acc, chip_last, seq_last, rep_last, gap_last, stop_hit;
  logic                      lfsr_step, lfsr_chip, lfsr_period_end;
  logic [15:0]               amp16, ch_a, ch_b;

  always_comb begin
    order_clamp = cfg_order;
    if (cfg_order < 5'(ORDER_MIN)) begin
      order_clamp = 5'(ORDER_MIN);
    end else if (cfg_order > 5'(LFSR_MAX_ORDER)) begin
      order_clamp = 5'(LFSR_MAX_ORDER);
    end
  end

  assign start_ok      = (state_q == ST_IDLE) && cfg_start;
  assign busy_o        = (state_q != ST_IDLE);
  assign m_axis_tvalid = busy_o;
  assign beat_acc      = busy_o && m_axis_tready;
  assign chip_last     = (div_cnt == div_q);
  assign seq_last      = (state_q == ST_RUN) && chip_last && lfsr_period_end;
  assign rep_last      = (rep_q != 8'd0) && (rep_cnt + 8'd1 == rep_q);
  assign gap_last      = (gap_cnt == gap_q - 16'd1);
  assign stop_hit      = cfg_stop || stop_pend;
  assign seq_end_o     = beat_acc && seq_last;
  assign lfsr_step     = beat_acc && (state_q == ST_RUN) && chip_last;
  // The LFSR is seeded from the live config while idle, then follows the latched order.
  assign lfsr_order    = busy_o ? order_q : order_clamp;

  always_comb begin
    state_nxt = state_q;
    done_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (beat_acc) begin
          if (stop_hit) begin
            state_nxt = ST_IDLE;
            done_o    = 1'b1;
          end else if (seq_last && rep_last) begin
            if (gap_q == 16'd0) begin
              state_nxt = ST_IDLE;
              done_o    = 1'b1;
            end else begin
              state_nxt = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (beat_acc && (stop_hit || gap_last)) begin
          state_nxt = ST_IDLE;
          done_o    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      order_q   <= 5'(ORDER_MIN);
      div_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      amp_q     <= '0;
      div_cnt   <= '0;
      rep_cnt   <= '0;
      gap_cnt   <= '0;
      stop_pend <= 1'b0;
    end else if (start_ok) begin
      order_q   <= order_clamp;
      div_q     <= cfg_div;
      rep_q     <= cfg_rep;
      gap_q     <= cfg_gap;
      amp_q     <= cfg_amp;
      div_cnt   <= '0;
      rep_cnt   <= '0;
      gap_cnt   <= '0;
      stop_pend <= 1'b0;
    end else if (busy_o) begin
      // A stop seen during a stall is remembered until the held beat is taken.
      if (cfg_stop && !m_axis_tready) stop_pend <= 1'b1;
      if (beat_acc) begin
        if (state_q == ST_RUN) begin
          div_cnt <= chip_last ? '0 : div_cnt + 1'b1;
          if (seq_last) rep_cnt <= rep_cnt + 8'd1;
        end else begin
          gap_cnt <= gap_cnt + 16'd1;
        end
      end
    end else begin
      stop_pend <= 1'b0;
    end
  end

  mls_lfsr #(
    .MAX_ORDER (LFSR_MAX_ORDER)
  ) u_lfsr (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .order      (lfsr_order),
    .seed       (start_ok),
    .step       (lfsr_step),
    .chip       (lfsr_chip),
    .period_end (lfsr_period_end)
  );

`ifdef MLS_MARKER_EN
  logic first_chip;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      first_chip <= 1'b0;
    end else if (start_ok) begin
      first_chip <= 1'b1;
    end else if (lfsr_step) begin
      first_chip <= seq_last;
    end
  end

  assign ch_b = ((state_q == ST_RUN) && first_chip) ? marker_value(DAC_DATA_WIDTH) : 16'd0;
`else
  assign ch_b = 16'd0;
`endif

  assign amp16 = 16'(amp_q);

  always_comb begin
    ch_a = 16'd0;
    if (state_q == ST_RUN) begin
      ch_a = lfsr_chip ? amp16 : 16'd0 - amp16;
    end
    m_axis_tdata = AXIS_TDATA_WIDTH'({ch_b, ch_a});
  end

endmodule

// File: tb/tb_axis_mls_burst_gen.sv
// Bench for axis_mls_burst_gen: table of burst configs checked beat by beat against an MLS
// recurrence model, plus hand sequences for stop, immediate stop and reset mid-burst.
module tb_axis_mls_burst_gen;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [4:0]  cfg_order = '0;
  logic [7:0]  cfg_div = '0;
  logic [7:0]  cfg_rep = '0;
  logic [15:0] cfg_gap = '0;
  logic [12:0] cfg_amp = '0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        busy_o, seq_end_o, done_o;

  int total = 0;
  int bad = 0;

  always #5 aclk = ~aclk;

  axis_mls_burst_gen dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_start     (cfg_start),
    .cfg_stop      (cfg_stop),
    .cfg_order     (cfg_order),
    .cfg_div       (cfg_div),
    .cfg_rep       (cfg_rep),
    .cfg_gap       (cfg_gap),
    .cfg_amp       (cfg_amp),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy_o        (busy_o),
    .seq_end_o     (seq_end_o),
    .done_o        (done_o)
  );

  typedef struct {
    int order;
    int div;
    int rep;
    int gap;
    int amp;
    bit rnd;
    int exp_beats;
    int exp_seq_ends;
    int exp_done_beat;
  } vec_t;

  vec_t        vecs[6];
  logic [33:0] exp_q[$];   // {seq_end, done, tdata}
  logic [33:0] ref_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic int eff_order(input int o);
    if (o < 2) return 2;
    if (o > 16) return 16;
    return o;
  endfunction

  // Middle exponents a of primitive x^n + x^a + ... + 1, as a bit set.
  function automatic int poly_terms(input int n);
    case (n)
      2: return 'h2;       3: return 'h4;       4: return 'h8;
      5: return 'h8;       6: return 'h20;      7: return 'h40;
      8: return 'h70;      9: return 'h20;      10: return 'h80;
      11: return 'h200;    12: return 'h52;     13: return 'h1A;
      14: return 'h2A;     15: return 'h4000;   16: return 'hA010;
      default: return 0;
    endcase
  endfunction

  task automatic build_model(input int order_cfg, input int div, input int rep, input int gap, input int amp);
    int          n, len, terms;
    bit          y[];
    bit          b;
    logic [15:0] pos, neg, cha, chb;
    logic [33:0] last;
    n     = eff_order(order_cfg);
    len   = (1 << n) - 1;
    terms = poly_terms(n);
    y     = new[len];
    for (int m = 0; m < len; m++) begin
      if (m < n) begin
        y[m] = 1'b1;
      end else begin
        b = y[m-n];
        for (int a = 1; a < n; a++) if (terms[a]) b ^= y[m-a];
        y[m] = b;
      end
    end
    pos = 16'(amp);
    neg = 16'd0 - pos;
    exp_q.delete();
    for (int r = 0; r < rep; r++)
      for (int c = 0; c < len; c++)
        for (int d = 0; d <= div; d++) begin
          cha = y[c] ? pos : neg;
          chb = 16'd0;
`ifdef MLS_MARKER_EN
          if (c == 0) chb = 16'd8191;
`endif
          exp_q.push_back({(c == len - 1 && d == div), 1'b0, chb, cha});
        end
    for (int g = 0; g < gap; g++) exp_q.push_back(34'd0);
    last = exp_q.pop_back();
    last[32] = 1'b1;
    exp_q.push_back(last);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int          acc_n, seq_n, done_at, cyc, limit;
    logic [31:0] prev_dat;
    bit          prev_pend;
    logic [33:0] e;
    acc_n = 0; seq_n = 0; done_at = -1; cyc = 0; prev_pend = 0; prev_dat = '0;
    build_model(v.order, v.div, v.rep, v.gap, v.amp);
    @(negedge aclk);
    cfg_order = 5'(v.order); cfg_div = 8'(v.div); cfg_rep = 8'(v.rep);
    cfg_gap = 16'(v.gap); cfg_amp = 13'(v.amp); cfg_start = 1'b1; m_axis_tready = 1'b0;
    #1 check($sformatf("v%0d_idle_tvalid", id), m_axis_tvalid, 1'b0);
    limit = v.exp_beats * 4 + 20;
    while (acc_n < v.exp_beats && cyc < limit) begin
      @(negedge aclk);
      m_axis_tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_start = (cyc % 7 == 3);
      cfg_order = 5'($urandom); cfg_div = 8'($urandom); cfg_rep = 8'($urandom);
      cfg_gap = 16'($urandom); cfg_amp = 13'($urandom);
      #1;
      if (cyc == 0) check($sformatf("v%0d_first_beat", id), m_axis_tvalid, 1'b1);
      if (prev_pend) check($sformatf("v%0d_stall_hold", id), {m_axis_tvalid, m_axis_tdata}, {1'b1, prev_dat});
      if (m_axis_tvalid && m_axis_tready) begin
        e = exp_q.pop_front();
        check($sformatf("v%0d_beat%0d", id, acc_n), {seq_end_o, done_o, m_axis_tdata}, e);
        if (seq_end_o) seq_n++;
        if (done_o) done_at = acc_n + 1;
        acc_n++;
      end else begin
        check($sformatf("v%0d_nobeat_flags", id), {seq_end_o, done_o}, 2'b00);
      end
      prev_pend = m_axis_tvalid && !m_axis_tready;
      prev_dat  = m_axis_tdata;
      cyc++;
    end
    check($sformatf("v%0d_beats", id), acc_n, v.exp_beats);
    check($sformatf("v%0d_seq_ends", id), seq_n, v.exp_seq_ends);
    check($sformatf("v%0d_done_beat", id), done_at, v.exp_done_beat);
    @(negedge aclk);
    cfg_start = 1'b0; m_axis_tready = 1'b1;
    #1 check($sformatf("v%0d_after_idle", id), {m_axis_tvalid, busy_o, done_o}, 3'b000);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //        order div rep gap amp  rnd beats seqs done
    vecs[0] = '{3,  0,  1,  0, 1000, 1'b0, 7,     1, 7};
    vecs[1] = '{4,  2,  2,  5, 500,  1'b0, 95,    2, 95};
    vecs[2] = '{5,  0,  1,  3, 8191, 1'b1, 34,    1, 34};
    vecs[3] = '{0,  1,  2,  0, 0,    1'b0, 12,    2, 12};
    vecs[4] = '{31, 0,  1,  1, 1,    1'b0, 65536, 1, 65536};
    vecs[5] = '{3,  1,  1,  2, 4095, 1'b1, 16,    1, 16};

    #1;
    check("reset_outputs", {m_axis_tvalid, busy_o, seq_end_o, done_o, m_axis_tdata}, 36'd0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    #1 check("post_reset_idle", {m_axis_tvalid, busy_o}, 2'b00);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Continuous order 2: start and stop together in IDLE (start wins), stop later while stalled.
    build_model(2, 0, 1, 0, 300);
    ref_q = exp_q;
    @(negedge aclk);
    cfg_order = 5'd2; cfg_div = 8'd0; cfg_rep = 8'd0; cfg_gap = 16'd0; cfg_amp = 13'd300;
    cfg_start = 1'b1; cfg_stop = 1'b1; m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      cfg_start = 1'b0; cfg_stop = 1'b0; m_axis_tready = 1'b1;
      #1 check($sformatf("cont_beat%0d", i), {m_axis_tvalid, done_o, m_axis_tdata}, {2'b10, ref_q[i % 3][31:0]});
    end
    @(negedge aclk);
    m_axis_tready = 1'b0; cfg_stop = 1'b1;
    #1 check("stop_stalled", {m_axis_tvalid, done_o, m_axis_tdata}, {2'b10, ref_q[1][31:0]});
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      cfg_stop = 1'b0;
      #1 check("stop_pending_hold", {m_axis_tvalid, done_o, m_axis_tdata}, {2'b10, ref_q[1][31:0]});
    end
    @(negedge aclk);
    m_axis_tready = 1'b1;
    #1 check("stop_final_beat", {m_axis_tvalid, done_o, m_axis_tdata}, {2'b11, ref_q[1][31:0]});
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      #1 check("stop_no_more_beats", {m_axis_tvalid, busy_o, done_o}, 3'b000);
    end

    // Immediate stop on the first beat with tready high.
    @(negedge aclk);
    cfg_order = 5'd0; cfg_div = 8'd1; cfg_rep = 8'd0; cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0; cfg_stop = 1'b1; m_axis_tready = 1'b1;
    #1 check("imm_stop_beat", {m_axis_tvalid, done_o, m_axis_tdata}, {2'b11, ref_q[0][31:0]});
    @(negedge aclk);
    cfg_stop = 1'b0;
    #1 check("imm_stop_idle", {m_axis_tvalid, done_o}, 2'b00);

    // Reset mid-burst: outputs drop at once, no done.
    @(negedge aclk);
    cfg_order = 5'd5; cfg_rep = 8'd0; cfg_div = 8'd0; cfg_amp = 13'd77; cfg_start = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      cfg_start = 1'b0;
    end
    #1 check("pre_reset_busy", {m_axis_tvalid, busy_o}, 2'b11);
    #1 aresetn = 1'b0;
    #1 check("async_reset", {m_axis_tvalid, busy_o, done_o, seq_end_o, m_axis_tdata}, 36'd0);
    @(negedge aclk);
    #1 check("reset_hold", {m_axis_tvalid, done_o}, 2'b00);
    aresetn = 1'b1;
    repeat (2) begin
      @(negedge aclk);
      #1 check("after_reset_idle", {m_axis_tvalid, busy_o, done_o}, 3'b000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
